pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and flow-control block for the 8-bit single-cycle processor. It holds the 32-bit PC and advances it by 4 each cycle. It redirects the PC on `j`, `beq` and `bne`, using the ALU's ZERO flag (the ALU result of the subtract used by branch compares) and the 8-bit signed word offset from the instruction. It sits between the control unit and ALU (its inputs) and the instruction memory (its output address). It stalls cleanly on memory BUSYWAIT.

## Interface
- `PC_WIDTH`, 32: width of PC and target arithmetic.
- `OFFSET_WIDTH`, 8: width of the signed instruction word offset.
- `CNT_WIDTH`, 16: width of the taken-redirect counter.

Ports:
- `CLK` in 1: single clock, all state updates on rising edge.
- `RESET` in 1: synchronous, active-high; sampled on `CLK` rising edge.
- `BUSYWAIT` in 1: memory stall; when 1, all state holds.
- `JUMP` in 1: unconditional redirect (`j`).
- `BRANCH` in 1: redirect if `ZERO`=1 (`beq`).
- `BRANCH_NE` in 1: redirect if `ZERO`=0 (`bne`).
- `OFFSET` in `OFFSET_WIDTH`: two's-complement word offset.
- `ZERO` in 1: ALU zero flag for the current instruction.
- `PC` out `PC_WIDTH`: registered instruction address.
- `PC_PLUS4` out `PC_WIDTH`: combinational `PC`+4.
- `FETCH_VALID` out 1: registered; 1 when `PC` addresses a valid fetch.
- `TAKEN` out 1: registered; 1 for the cycle following an accepted redirect.
- `TAKEN_COUNT` out `CNT_WIDTH`: registered saturating count of accepted redirects.

## Operation
- **States:** START and RUN.
  - RESET forces START.
  - START → RUN on the next edge with `RESET`=0, regardless of `BUSYWAIT`.
  - RUN holds until RESET.
- **START:** `PC` held at 0, `FETCH_VALID`=0, `TAKEN`=0, redirect inputs ignored. The first valid fetch is address 0.
- **RUN:** `FETCH_VALID`=1. At each edge with `BUSYWAIT`=0, `PC` loads `next`.
- **Target:** `target` = `PC` + 4 + (sign_extend(`OFFSET`) << 2), modulo 2^`PC_WIDTH`. Wrap-around is silent, with no flag.
- **Next-PC priority:**
  1. `JUMP`=1 → `target`.
  2. `BRANCH`=1 and `ZERO`=1 → `target`.
  3. `BRANCH_NE`=1 and `ZERO`=0 → `target`.
  4. Otherwise → `PC_PLUS4`.
- **Overlapping controls:** `BRANCH` and `BRANCH_NE` both 1 is therefore always taken. This is legal and defined.
- **Redirect accepted:** in RUN, `BUSYWAIT`=0 and any of rules 1–3 holds.
  - `TAKEN` is set to 1 for one cycle.
  - `TAKEN_COUNT` increments, saturating at all-ones.
- **Stall:** at an edge with `BUSYWAIT`=1, `PC` and `TAKEN_COUNT` hold and `TAKEN` is cleared to 0. Redirect inputs present during the stall are not latched; they are evaluated only at the releasing edge.
- **`PC_PLUS4`:** always `PC`+4, including in START and during stalls.

## Timing
- **Reset values (edge with `RESET`=1):** `PC`=0, `FETCH_VALID`=0, `TAKEN`=0, `TAKEN_COUNT`=0, state START.
- **Reset priority:** reset overrides `BUSYWAIT` and all redirect inputs. Reset mid-stall or mid-redirect discards the pending update.
- **Redirect latency:** redirect inputs sampled at edge N → new `PC` visible after edge N. One-cycle latency, no delay slot.
- **Startup sequence:**
  - Edge 0 (`RESET`=1): START.
  - Edge 1 (`RESET`=0): RUN, `PC`=0.
  - Edge 2: first advance, `PC`=4.
- **Input validity:** `ZERO` and `OFFSET` must be stable before the edge. The block does not register them.
- **Output timing:** `TAKEN` and `FETCH_VALID` change only on edges.

## Test plan
- **Reset and startup:** assert `RESET` for 2 cycles, then release with no controls. Expect `PC` = 0, 0, 0, 4, 8; `FETCH_VALID` rises coincident with RUN; `TAKEN_COUNT`=0.
- **beq taken / not taken:** at `PC`=0x10, `BRANCH`=1, `OFFSET`=0x02, `ZERO`=1 → `PC`=0x1C, `TAKEN`=1 for one cycle, count=1. Repeat with `ZERO`=0 → `PC`=0x14, `TAKEN`=0.
- **Backward jump and wrap:**
  - At `PC`=0x20, `JUMP`=1, `OFFSET`=0xF7 (−9) → `PC`=0x00.
  - At `PC`=0x00, `JUMP`=1, `OFFSET`=0x80 → `PC`=0xFFFFFE04.
- **Stall:**
  - At `PC`=0x08 with `BNE`=1, `ZERO`=0, hold `BUSYWAIT`=1 for 3 cycles. Expect `PC` stays 0x08 and `TAKEN` stays 0.
  - Release with the same inputs → `PC`=0x0C+(`OFFSET`<<2), count +1.
- **Priority:** `JUMP`=1 with `BRANCH`=1 and `ZERO`=0 → jump taken. `BRANCH`=`BRANCH_NE`=1 → taken for both `ZERO` values.
- **Saturation and reset mid-stall:**
  - Force 65537 accepted redirects → `TAKEN_COUNT`=0xFFFF.
  - Assert `RESET` while `BUSYWAIT`=1 → all outputs reach their reset values at that edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter and redirect logic: PC+4 sequencing, j/beq/bne targets, saturating count of taken redirects.
// Latency: a redirect sampled at an edge sets PC at that same edge. There is no delay slot.
// Backpressure: BUSYWAIT=1 freezes PC and TAKEN_COUNT and clears TAKEN. Redirect inputs are not latched during a stall.
module pc_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int OFFSET_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BUSYWAIT,
    input  logic                    JUMP,
    input  logic                    BRANCH,
    input  logic                    BRANCH_NE,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic                    ZERO,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     PC_PLUS4,
    output logic                    FETCH_VALID,
    output logic                    TAKEN,
    output logic [CNT_WIDTH-1:0]    TAKEN_COUNT
);

    typedef enum logic {
        ST_START = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] next_pc;
    logic                redirect;
    logic                advance;
    logic                accept;
    logic                cnt_sat;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // START lasts exactly one non-reset edge. BUSYWAIT does not delay it.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        case (state)
            ST_START: next_state = ST_RUN;
            ST_RUN:   advance    = !BUSYWAIT;
            default:  next_state = ST_START;
        endcase
    end

    // Target arithmetic wraps modulo 2^PC_WIDTH with no overflow flag.
    always_comb begin
        offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}}, OFFSET};
        PC_PLUS4   = PC + PC_WIDTH'(4);
        target     = PC_PLUS4 + {offset_ext[PC_WIDTH-3:0], 2'b00};
    end

    // BRANCH and BRANCH_NE both set is taken for either ZERO value.
    always_comb begin
        redirect = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);
        next_pc  = redirect ? target : PC_PLUS4;
        accept   = advance & redirect;
        cnt_sat  = (TAKEN_COUNT == {CNT_WIDTH{1'b1}});
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC          <= '0;
            FETCH_VALID <= 1'b0;
            TAKEN       <= 1'b0;
            TAKEN_COUNT <= '0;
        end else begin
            FETCH_VALID <= (next_state == ST_RUN);
            TAKEN       <= accept;
            if (advance) begin
                PC <= next_pc;
            end
            if (accept && !cnt_sat) begin
                TAKEN_COUNT <= TAKEN_COUNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Randomized and directed bench for pc_unit, checked against a behavioural model.
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BUSYWAIT = 1'b0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        BRANCH_NE = 1'b0;
    logic [7:0]  OFFSET = 8'h00;
    logic        ZERO = 1'b0;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_VALID;
    logic        TAKEN;
    logic [15:0] TAKEN_COUNT;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b1;

    // Behavioural model state
    logic [31:0] m_pc = '0;
    bit          m_run = 1'b0;
    bit          m_taken = 1'b0;
    int          m_cnt = 0;

    pc_unit #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP),
        .BRANCH(BRANCH), .BRANCH_NE(BRANCH_NE), .OFFSET(OFFSET), .ZERO(ZERO),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .FETCH_VALID(FETCH_VALID),
        .TAKEN(TAKEN), .TAKEN_COUNT(TAKEN_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit take;
        if (RESET) begin
            m_pc = '0; m_run = 0; m_taken = 0; m_cnt = 0;
        end else if (!m_run) begin
            m_run = 1; m_taken = 0;
        end else if (BUSYWAIT) begin
            m_taken = 0;
        end else begin
            take = JUMP || (BRANCH && ZERO) || (BRANCH_NE && !ZERO);
            if (take) m_pc = m_pc + 32'd4 + 32'($signed(OFFSET) * 4);
            else      m_pc = m_pc + 32'd4;
            m_taken = take;
            if (take && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        if (check_en) begin
            chk("model_pc", PC, m_pc);
            chk("model_pc_plus4", PC_PLUS4, m_pc + 32'd4);
            chk("model_fetch_valid", {31'b0, FETCH_VALID}, {31'b0, m_run});
            chk("model_taken", {31'b0, TAKEN}, {31'b0, m_taken});
            chk("model_count", {16'b0, TAKEN_COUNT}, 32'(m_cnt));
        end
    endtask

    task automatic ctl(input bit j, input bit b, input bit bne, input bit z, input logic [7:0] off);
        JUMP = j; BRANCH = b; BRANCH_NE = bne; ZERO = z; OFFSET = off;
    endtask

    task automatic do_reset();
        RESET = 1'b1; BUSYWAIT = 1'b0; ctl(0, 0, 0, 0, 8'h00);
        step();
        RESET = 1'b0;
    endtask

    initial begin
        // Reset and startup: PC = 0,0,0,4,8
        RESET = 1'b1;
        step();
        chk("rst_pc0", PC, 32'h0);
        step();
        chk("rst_pc1", PC, 32'h0);
        chk("rst_fv", {31'b0, FETCH_VALID}, 32'h0);
        chk("rst_cnt", {16'b0, TAKEN_COUNT}, 32'h0);
        RESET = 1'b0;
        step();
        chk("start_pc", PC, 32'h0);
        chk("start_fv", {31'b0, FETCH_VALID}, 32'h1);
        step();
        chk("adv_pc4", PC, 32'h4);
        step();
        chk("adv_pc8", PC, 32'h8);
        chk("adv_cnt", {16'b0, TAKEN_COUNT}, 32'h0);
        step(); step();
        chk("at_pc10", PC, 32'h10);

        // beq taken, then not taken
        ctl(0, 1, 0, 1, 8'h02);
        step();
        chk("beq_pc", PC, 32'h1C);
        chk("beq_taken", {31'b0, TAKEN}, 32'h1);
        chk("beq_cnt", {16'b0, TAKEN_COUNT}, 32'h1);
        ctl(0, 1, 0, 0, 8'h02);
        step();
        chk("beq_nt_pc", PC, 32'h20);
        chk("beq_nt_taken", {31'b0, TAKEN}, 32'h0);

        // Backward jump to 0, then wrap below 0
        ctl(1, 0, 0, 0, 8'hF7);
        step();
        chk("jback_pc", PC, 32'h0);
        ctl(1, 0, 0, 0, 8'h80);
        step();
        chk("jwrap_pc", PC, 32'hFFFFFE04);
        chk("jwrap_cnt", {16'b0, TAKEN_COUNT}, 32'h3);

        // Stall at PC=0x08 with a pending bne
        do_reset();
        step(); step(); step();
        chk("stall_start_pc", PC, 32'h8);
        ctl(0, 0, 1, 0, 8'h03);
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'h8);
            chk("stall_taken", {31'b0, TAKEN}, 32'h0);
        end
        BUSYWAIT = 1'b0;
        step();
        chk("release_pc", PC, 32'h18);
        chk("release_cnt", {16'b0, TAKEN_COUNT}, 32'h1);

        // Priority and overlapping branch controls
        ctl(1, 1, 0, 0, 8'h01);
        step();
        chk("prio_jump_pc", PC, 32'h20);
        ctl(0, 1, 1, 0, 8'h01);
        step();
        chk("both_z0_pc", PC, 32'h28);
        ctl(0, 1, 1, 1, 8'h01);
        step();
        chk("both_z1_pc", PC, 32'h30);
        chk("both_cnt", {16'b0, TAKEN_COUNT}, 32'h4);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            RESET     = ($urandom_range(0, 99) == 0);
            BUSYWAIT  = ($urandom_range(0, 3) == 0);
            JUMP      = ($urandom_range(0, 7) == 0);
            BRANCH    = 1'($urandom_range(0, 1));
            BRANCH_NE = 1'($urandom_range(0, 1));
            ZERO      = 1'($urandom_range(0, 1));
            OFFSET    = 8'($urandom);
            step();
        end

        // Saturation: 65537 accepted redirects
        do_reset();
        step();
        check_en = 1'b0;
        ctl(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 65537; i++) step();
        check_en = 1'b1;
        chk("sat_cnt", {16'b0, TAKEN_COUNT}, 32'hFFFF);
        chk("sat_model_cnt", {16'b0, TAKEN_COUNT}, 32'(m_cnt));
        chk("sat_pc", PC, m_pc);
        step();
        chk("sat_hold_cnt", {16'b0, TAKEN_COUNT}, 32'hFFFF);

        // Reset during a stall with a redirect pending
        BUSYWAIT = 1'b1;
        step();
        RESET = 1'b1;
        step();
        chk("rst_stall_pc", PC, 32'h0);
        chk("rst_stall_fv", {31'b0, FETCH_VALID}, 32'h0);
        chk("rst_stall_taken", {31'b0, TAKEN}, 32'h0);
        chk("rst_stall_cnt", {16'b0, TAKEN_COUNT}, 32'h0);
        RESET = 1'b0; BUSYWAIT = 1'b0; ctl(0, 0, 0, 0, 8'h00);
        step();
        step();
        chk("post_rst_pc", PC, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
